// File: rtl/wc_tile_sched_if.sv
// Handshake bundle for the F(5,3) Winograd tile scheduler:
// sample stream in, window/results to and from the core, tiles out.
interface wc_tile_sched_if #(
  parameter int DW = 10
);
  logic            s_valid;
  logic [DW-1:0]   s_data;
  logic            s_ready;
  logic [7*DW-1:0] wc_d;
  logic            wc_issue;
  logic [5*DW-1:0] wc_z;
  logic            m_valid;
  logic [5*DW-1:0] m_data;
  logic            m_last;
  logic            m_ready;
  logic            busy;

  modport slave (
    input  s_valid, s_data, wc_z, m_ready,
    output s_ready, wc_d, wc_issue,
    output m_valid, m_data, m_last, busy
  );

  modport master (
    output s_valid, s_data, wc_z, m_ready,
    input  s_ready, wc_d, wc_issue,
    input  m_valid, m_data, m_last, busy
  );
endinterface

// File: rtl/wc_tile_sched.sv
// Streaming tile scheduler: 7-sample windows at stride 5 to the
// Winograd core, results buffered in a credit-guarded FIFO.
module wc_tile_sched #(
  parameter int DW       = 10,
  parameter int LINE_LEN = 32,
  parameter int WC_LAT   = 2,
  parameter int OF_DEPTH = 4
) (
  input  logic           clk,
  input  logic           rst,
  wc_tile_sched_if.slave bus
);
  localparam int TILES = (LINE_LEN - 2) / 5;
  localparam int TW    = $clog2(TILES + 1);
  localparam int AW    = $clog2(OF_DEPTH);
  localparam int CW    = $clog2(OF_DEPTH + WC_LAT + 1) + 1;
  localparam int ZW    = 5 * DW;
  localparam int EW    = ZW + 1;

  typedef enum logic [1:0] {
    FILL,
    STEP,
    ISSUE
  } state_e;

  state_e          state_q;
  logic [2:0]      fill_q;
  logic [TW-1:0]   tile_q;
  logic [7*DW-1:0] win_q;

  logic [WC_LAT-1:0] tv_q;
  logic [WC_LAT-1:0] tl_q;

  logic [EW-1:0] mem_q [OF_DEPTH];
  logic [AW-1:0] wp_q;
  logic [AW-1:0] rp_q;
  logic [AW:0]   cnt_q;
  logic [AW:0]   cnt_d;

  logic          acc;
  logic          issue;
  logic          credit;
  logic          tile_last;
  logic [2:0]    fill_tgt;
  logic [CW-1:0] infl;
  logic [CW-1:0] used;
  logic          push;
  logic          pop;
  logic [EW-1:0] head;

  always_comb begin
    infl = '0;
    for (int k = 0; k < WC_LAT; k++) begin
      infl = infl + CW'(tv_q[k]);
    end
  end

  // Slots already spoken for: buffered tiles plus tiles in the core.
  assign used      = CW'(cnt_q) + infl;
  assign credit    = used < CW'(OF_DEPTH);
  assign issue     = (state_q == ISSUE) & credit;
  assign tile_last = tile_q == TW'(TILES - 1);
  assign fill_tgt  = (state_q == FILL) ? 3'd6 : 3'd4;
  assign acc       = bus.s_valid & bus.s_ready;
  assign push      = tv_q[WC_LAT-1];
  assign pop       = bus.m_valid & bus.m_ready;
  assign head      = mem_q[rp_q];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= FILL;
      fill_q  <= '0;
      tile_q  <= '0;
      win_q   <= '0;
    end else begin
      if (acc) begin
        win_q <= {bus.s_data, win_q[7*DW-1:DW]};
      end
      unique case (state_q)
        FILL, STEP: begin
          if (acc) begin
            if (fill_q == fill_tgt) begin
              fill_q  <= '0;
              state_q <= ISSUE;
            end else begin
              fill_q <= fill_q + 3'd1;
            end
          end
        end
        ISSUE: begin
          if (credit) begin
            if (tile_last) begin
              tile_q  <= '0;
              win_q   <= '0;
              state_q <= FILL;
            end else begin
              tile_q  <= tile_q + TW'(1);
              state_q <= STEP;
            end
          end
        end
        default: state_q <= FILL;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tv_q <= '0;
      tl_q <= '0;
    end else begin
      tv_q[0] <= issue;
      tl_q[0] <= tile_last;
      for (int k = 1; k < WC_LAT; k++) begin
        tv_q[k] <= tv_q[k-1];
        tl_q[k] <= tl_q[k-1];
      end
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (push && !pop) begin
      cnt_d = cnt_q + (AW+1)'(1);
    end else if (pop && !push) begin
      cnt_d = cnt_q - (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      if (push) begin
        wp_q <= wp_q + AW'(1);
      end
      if (pop) begin
        rp_q <= rp_q + AW'(1);
      end
    end
  end

  // Storage needs no reset; the head is masked while empty.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wp_q] <= {tl_q[WC_LAT-1], bus.wc_z};
    end
  end

  assign bus.s_ready  = ~rst & (state_q != ISSUE);
  assign bus.wc_d     = win_q;
  assign bus.wc_issue = issue;
  assign bus.m_valid  = cnt_q != '0;
  assign bus.m_data   = bus.m_valid ? head[ZW-1:0] : '0;
  assign bus.m_last   = bus.m_valid & head[EW-1];
  assign bus.busy     = (state_q != FILL) | (fill_q != '0) |
                        (infl != '0) | (cnt_q != '0);
endmodule
